// File: rtl/instr_issue_ctrl.sv
// Instruction issue controller: buffers loader words in a FIFO and feeds them one per
// cycle to the processor, sequencing its reset, stall bubbles and halt-time pipeline flush.
module instr_issue_ctrl #(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 8,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0,
  parameter int                     FLUSH_CYC   = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load_valid,
  input  logic [INSTR_WIDTH-1:0]   i_load_instr,
  output logic                     o_load_ready,
  input  logic                     i_start,
  input  logic                     i_stall_in,
  input  logic                     i_halt_req,
  output logic [INSTR_WIDTH-1:0]   o_instr_out,
  output logic                     o_issue_valid,
  output logic                     o_proc_rst,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic [15:0]              o_issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  logic [INSTR_WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [AW:0]              r_count;
  logic [INSTR_WIDTH-1:0]   r_instr_out;
  logic                     r_issue_valid;
  logic                     r_proc_rst;
  logic                     r_done;
  logic [15:0]              r_issued_cnt;
  logic [FW-1:0]            r_flush_cnt;

  logic w_load_ready;
  logic w_not_empty;
  logic w_push;
  logic w_pop;

  // Pop/empty decisions use the registered count, so a word written this edge can never bypass.
  assign w_load_ready = (r_count != (AW + 1)'(DEPTH));
  assign w_not_empty  = (r_count != '0);
  assign w_push       = i_load_valid & w_load_ready;
  assign w_pop        = (r_state == S_RUN) & ~i_halt_req & ~i_stall_in & w_not_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_load_instr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_instr_out   <= NOP_WORD;
      r_issue_valid <= 1'b0;
      r_proc_rst    <= 1'b1;
      r_done        <= 1'b0;
      r_issued_cnt  <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_instr_out   <= NOP_WORD;
          r_issue_valid <= 1'b0;
          r_proc_rst    <= 1'b1;
          if (i_start && w_not_empty) begin
            r_state      <= S_RUN;
            r_proc_rst   <= 1'b0;
            r_issued_cnt <= '0;
          end
        end
        S_RUN: begin
          // Halt wins over both pop and stall; the halt edge already drives a bubble.
          if (i_halt_req) begin
            r_state       <= S_DRAIN;
            r_instr_out   <= NOP_WORD;
            r_issue_valid <= 1'b0;
            r_flush_cnt   <= '0;
          end else if (i_stall_in) begin
            r_instr_out   <= r_instr_out;
            r_issue_valid <= r_issue_valid;
          end else if (w_not_empty) begin
            r_instr_out   <= r_mem[r_rd_ptr];
            r_issue_valid <= 1'b1;
            r_issued_cnt  <= r_issued_cnt + 16'd1;
          end else begin
            r_instr_out   <= NOP_WORD;
            r_issue_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_instr_out   <= NOP_WORD;
          r_issue_valid <= 1'b0;
          if (!i_stall_in) begin
            if (r_flush_cnt == FW'(FLUSH_CYC - 1)) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_proc_rst  <= 1'b1;
              r_flush_cnt <= '0;
            end else begin
              r_flush_cnt <= r_flush_cnt + FW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_load_ready  = w_load_ready;
  assign o_instr_out   = r_instr_out;
  assign o_issue_valid = r_issue_valid;
  assign o_proc_rst    = r_proc_rst;
  assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done        = r_done;
  assign o_fifo_count  = r_count;
  assign o_issued_cnt  = r_issued_cnt;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: accepted loads feed an expected-word queue that a monitor
// drains whenever issued_cnt steps, alongside directed checks of sequencing and boundaries.
module tb_instr_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_instr;
  logic        load_ready;
  logic        start;
  logic        stall_in;
  logic        halt_req;
  logic [31:0] instr_out;
  logic        issue_valid;
  logic        proc_rst;
  logic        busy;
  logic        done;
  logic [3:0]  fifo_count;
  logic [15:0] issued_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb [$];
  logic [15:0] last_cnt;
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  instr_issue_ctrl #(
    .INSTR_WIDTH(32),
    .DEPTH      (8),
    .NOP_WORD   (32'h0),
    .FLUSH_CYC  (5)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_valid (load_valid),
    .i_load_instr (load_instr),
    .o_load_ready (load_ready),
    .i_start      (start),
    .i_stall_in   (stall_in),
    .i_halt_req   (halt_req),
    .o_instr_out  (instr_out),
    .o_issue_valid(issue_valid),
    .o_proc_rst   (proc_rst),
    .o_busy       (busy),
    .o_done       (done),
    .o_fifo_count (fifo_count),
    .o_issued_cnt (issued_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    load_valid = 1'b1;
    load_instr = w;
    if (load_ready) sb.push_back(w);
    $display("[TB] load %h ready=%0b", w, load_ready);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic halt_and_drain(input logic [3:0] exp_count);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("halt_busy",  32'(busy), 32'd1);
    check_eq("halt_valid", 32'(issue_valid), 32'd0);
    check_eq("halt_nop",   instr_out, NOP);
    check_eq("halt_count", 32'(fifo_count), 32'(exp_count));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("drain_done", 32'(done), 32'd0);
      check_eq("drain_busy", 32'(busy), 32'd1);
      check_eq("drain_nop",  instr_out, NOP);
    end
    tick();
    check_eq("done_pulse",  32'(done), 32'd1);
    check_eq("done_prst",   32'(proc_rst), 32'd1);
    check_eq("done_busy",   32'(busy), 32'd0);
    check_eq("done_count",  32'(fifo_count), 32'(exp_count));
    check_eq("sb_vs_count", 32'(fifo_count), 32'(sb.size()));
    tick();
    check_eq("done_once",   32'(done), 32'd0);
    $display("[TB] drain complete, fifo_count=%0d", fifo_count);
  endtask

  // Monitor: a +1 step of issued_cnt marks a fresh pop; a step to 0 is the start-edge clear.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_cnt = 16'd0;
    end else if (issued_cnt == last_cnt + 16'd1) begin
      if (sb.size() == 0) begin
        check_eq("sb_pop_empty", 32'(sb.size()), 32'd1);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("sb_instr", instr_out, mon_exp);
        check_eq("sb_valid", 32'(issue_valid), 32'd1);
        $display("[TB] issue %h (cnt %0d)", instr_out, issued_cnt);
      end
      last_cnt = issued_cnt;
    end else if (issued_cnt != last_cnt) begin
      if (issued_cnt != 16'd0) check_eq("cnt_step", 32'(issued_cnt), 32'(last_cnt + 16'd1));
      last_cnt = issued_cnt;
    end
  end

  initial begin
    logic [31:0] t1 [5];
    t1[0] = 32'h0A002080; t1[1] = 32'h00084004; t1[2] = 32'h0008600C;
    t1[3] = 32'h00188214; t1[4] = 32'h3402A084;

    rst_n = 1'b1; load_valid = 1'b0; load_instr = '0;
    start = 1'b0; stall_in = 1'b0; halt_req = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_instr", instr_out, NOP);
    check_eq("rst_valid", 32'(issue_valid), 32'd0);
    check_eq("rst_prst",  32'(proc_rst), 32'd1);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_cnt",   32'(issued_cnt), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_eq("rst_ready", 32'(load_ready), 32'd1);

    // 1: preload five words, start, expect five back-to-back issues
    for (int i = 0; i < 5; i++) push_word(t1[i]);
    check_eq("t1_count", 32'(fifo_count), 32'd5);
    check_eq("t1_prst_idle", 32'(proc_rst), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_prst_run", 32'(proc_rst), 32'd0);
    check_eq("t1_busy",     32'(busy), 32'd1);
    check_eq("t1_nopop",    32'(issue_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t1_word",  instr_out, t1[i]);
      check_eq("t1_valid", 32'(issue_valid), 32'd1);
    end
    tick();
    check_eq("t1_under_valid", 32'(issue_valid), 32'd0);
    check_eq("t1_under_nop",   instr_out, NOP);
    check_eq("t1_issued",      32'(issued_cnt), 32'd5);

    // 6: empty in RUN, push one word: one bubble, then it issues
    push_word(32'hCAFE0001);
    check_eq("t6_bubble_valid", 32'(issue_valid), 32'd0);
    check_eq("t6_bubble_nop",   instr_out, NOP);
    tick();
    check_eq("t6_word",   instr_out, 32'hCAFE0001);
    check_eq("t6_valid",  32'(issue_valid), 32'd1);
    check_eq("t6_issued", 32'(issued_cnt), 32'd6);

    // 4: queue five under stall, issue two, halt with three still queued
    stall_in = 1'b1;
    push_word(32'h11111111);
    push_word(32'h22222222);
    for (int i = 0; i < 3; i++) push_word(t1[i]);
    check_eq("t4_stall_hold", instr_out, 32'hCAFE0001);
    check_eq("t4_count5", 32'(fifo_count), 32'd5);
    stall_in = 1'b0;
    tick();
    tick();
    check_eq("t4_issued", 32'(issued_cnt), 32'd8);
    halt_and_drain(4'd3);

    // 3: restart, stall three cycles on word 2
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t3_cnt_clear", 32'(issued_cnt), 32'd0);
    tick();
    tick();
    check_eq("t3_word2", instr_out, 32'h00084004);
    check_eq("t3_cnt2",  32'(issued_cnt), 32'd2);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_hold",      instr_out, 32'h00084004);
      check_eq("t3_hold_cnt",  32'(issued_cnt), 32'd2);
      check_eq("t3_hold_vld",  32'(issue_valid), 32'd1);
    end
    stall_in = 1'b0;
    tick();
    check_eq("t3_word3", instr_out, 32'h0008600C);
    check_eq("t3_cnt3",  32'(issued_cnt), 32'd3);
    halt_and_drain(4'd0);

    // 2: fill in IDLE with nine attempts; the ninth is refused
    for (int i = 0; i < 9; i++) push_word(32'hA0000000 + 32'(i));
    check_eq("t2_count", 32'(fifo_count), 32'd8);
    check_eq("t2_ready", 32'(load_ready), 32'd0);
    check_eq("t2_sb",    32'(sb.size()), 32'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_valid = 1'b1;
    load_instr = 32'hDEADBEEF;
    check_eq("t2_full_ready", 32'(load_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    check_eq("t2_full_pop", 32'(fifo_count), 32'd7);
    tick();
    tick();
    check_eq("t2_count5", 32'(fifo_count), 32'd5);

    // 5: asynchronous reset between edges while running
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    check_eq("t5_prst",  32'(proc_rst), 32'd1);
    check_eq("t5_valid", 32'(issue_valid), 32'd0);
    check_eq("t5_instr", instr_out, NOP);
    check_eq("t5_busy",  32'(busy), 32'd0);
    check_eq("t5_count", 32'(fifo_count), 32'd0);
    check_eq("t5_cnt",   32'(issued_cnt), 32'd0);
    check_eq("t5_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_nodone", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_nodone_post", 32'(done), 32'd0);
      check_eq("t5_idle",        32'(busy), 32'd0);
    end
    push_word(32'h12345678);
    check_eq("t5_repush", 32'(fifo_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
